// File: rtl/dds_pkg.sv
// Shared types for the DDS waveform generator: output mode encoding and the
// control word that travels down the pipeline beside the phase bits.
package dds_pkg;

  typedef enum logic [1:0] {
    MODE_SINE = 2'd0,
    MODE_TRI  = 2'd1,
    MODE_SAW  = 2'd2,
    MODE_SQR  = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e mode;
    logic  wrap;
    logic  valid;
  } stage_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sine_qw_rom.sv
// Quarter-wave sine ROM with a registered read port. Entry i holds
// round((2^DATA_W-1) * sin(pi/2 * (i+0.5) / 2^ADDR_W)), built at elaboration.
module sine_qw_rom #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam int     DEPTH      = 1 << ADDR_W;
  localparam longint AMP        = (longint'(1) << DATA_W) - 1;
  localparam longint HALF_PI_FX = 64'sd1686629713;  // pi/2 in Q30

  // Q30 Taylor series; error is far below the half-LSB rounding threshold.
  function automatic logic [DATA_W-1:0] entry(input int i);
    longint x, x2, term, acc, val;
    x    = (HALF_PI_FX * longint'(2 * i + 1)) / longint'(2 * DEPTH);
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int k = 1; k <= 8; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      acc  = acc + term;
    end
    val = (AMP * acc + (longint'(1) <<< 29)) >>> 30;
    return DATA_W'(val);
  endfunction

  logic [DATA_W-1:0] rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam logic [DATA_W-1:0] VAL = entry(g);
    assign rom[g] = VAL;
  end

  always_ff @(posedge clk) begin
    data <= rom[addr];
  end

endmodule

// File: rtl/dds_wave_gen.sv
// Direct-digital-synthesis generator: phase accumulator, quarter-wave sine
// lookup and a registered sine/triangle/saw/square mux, offset-binary output.
module dds_wave_gen
  import dds_pkg::*;
#(
  parameter int PHASE_W    = 16,
  parameter int LUT_ADDR_W = 7,
  parameter int OUT_W      = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               phase_clr,
  input  logic [PHASE_W-1:0] ftw,
  input  logic               ftw_load,
  input  logic [1:0]         mode,
  output logic [OUT_W-1:0]   sample,
  output logic               sample_valid,
  output logic               wrap
);

  // Top phase bits needed downstream: ROM quadrant/index and the OUT_W+1 bits
  // used by the direct (non-sine) waveforms.
  localparam int KEEP_W = max_int(OUT_W + 1, LUT_ADDR_W + 2);
  localparam logic [OUT_W-1:0] MID    = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] MID_M1 = {1'b0, {(OUT_W-1){1'b1}}};

  function automatic logic [OUT_W-1:0] sine_unfold(input logic neg,
                                                   input logic [OUT_W-2:0] mag);
    return neg ? (MID_M1 - {1'b0, mag}) : (MID + {1'b0, mag});
  endfunction

  function automatic logic [OUT_W-1:0] wave_sel(input mode_e md,
                                                input logic [OUT_W:0] ph,
                                                input logic [OUT_W-2:0] mag);
    case (md)
      MODE_SINE: return sine_unfold(ph[OUT_W], mag);
      MODE_TRI:  return ph[OUT_W] ? ~ph[OUT_W-1:0] : ph[OUT_W-1:0];
      MODE_SAW:  return ph[OUT_W -: OUT_W];
      default:   return ph[OUT_W] ? {OUT_W{1'b0}} : {OUT_W{1'b1}};
    endcase
  endfunction

  logic [PHASE_W-1:0]    acc;
  logic [PHASE_W-1:0]    ftw_r;
  logic [PHASE_W:0]      acc_sum;
  logic                  acc_carry;
  stage_t                ctl_p1, ctl_p2;
  logic [KEEP_W-1:0]     phase_p1;
  logic [OUT_W:0]        phase_p2;
  logic [LUT_ADDR_W-1:0] idx_p1, rom_addr;
  logic [OUT_W-2:0]      mag_p2;

  assign acc_sum   = {1'b0, acc} + {1'b0, ftw_r};
  assign acc_carry = acc_sum[PHASE_W] & enable & ~phase_clr;

  // ---- S0: accumulator and tuning register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      ftw_r <= '0;
    end else begin
      if (phase_clr)   acc <= '0;
      else if (enable) acc <= acc_sum[PHASE_W-1:0];
      if (ftw_load)    ftw_r <= ftw;
    end
  end

  // ---- S1: capture pre-increment phase, mode, carry and valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ctl_p1 <= '{mode: MODE_SINE, wrap: 1'b0, valid: 1'b0};
    else     ctl_p1 <= '{mode: mode_e'(mode), wrap: acc_carry, valid: enable};
  end

  always_ff @(posedge clk) begin
    phase_p1 <= acc[PHASE_W-1 -: KEEP_W];
  end

  assign idx_p1   = phase_p1[KEEP_W-3 -: LUT_ADDR_W];
  assign rom_addr = phase_p1[KEEP_W-2] ? ~idx_p1 : idx_p1;

  // ---- S2: ROM read, phase and control carried alongside
  sine_qw_rom #(
    .ADDR_W (LUT_ADDR_W),
    .DATA_W (OUT_W - 1)
  ) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (mag_p2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ctl_p2 <= '{mode: MODE_SINE, wrap: 1'b0, valid: 1'b0};
    else     ctl_p2 <= ctl_p1;
  end

  always_ff @(posedge clk) begin
    phase_p2 <= phase_p1[KEEP_W-1 -: OUT_W+1];
  end

  // ---- S3: registered output mux; sample holds across bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample       <= MID;
      sample_valid <= 1'b0;
      wrap         <= 1'b0;
    end else begin
      sample_valid <= ctl_p2.valid;
      wrap         <= ctl_p2.valid & ctl_p2.wrap;
      if (ctl_p2.valid) sample <= wave_sel(ctl_p2.mode, phase_p2, mag_p2);
    end
  end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Directed bench for dds_wave_gen: vector table for start-up and control
// sequences, captured-sample sweeps for each waveform, async reset corner.
module tb_dds_wave_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic        ld = 1'b0;
  logic [15:0] ftw = '0;
  logic [1:0]  mode = '0;
  logic [9:0]  sample;
  logic        sample_valid;
  logic        wrap;

  int n_cmp = 0;
  int n_bad = 0;
  int s_q[$];
  int w_q[$];

  typedef struct {
    logic        en;
    logic        clr;
    logic        ld;
    logic [15:0] ftw;
    logic [1:0]  mode;
    logic        exp_v;
    int          exp_s;
    logic        exp_w;
  } vec_t;

  vec_t tbl [30];

  always #5 clk = ~clk;

  dds_wave_gen dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (en),
    .phase_clr    (clr),
    .ftw          (ftw),
    .ftw_load     (ld),
    .mode         (mode),
    .sample       (sample),
    .sample_valid (sample_valid),
    .wrap         (wrap)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    en = 1'b0; clr = 1'b0; ld = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic load(input logic [15:0] word, input logic [1:0] md);
    ftw = word; mode = md; ld = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    ld = 1'b0;
  endtask

  task automatic run_en(input int n);
    s_q.delete();
    w_q.delete();
    for (int c = 0; c < n + 3; c++) begin
      en = (c < n);
      @(posedge clk); #1;
      if (sample_valid) begin
        s_q.push_back(int'(sample));
        w_q.push_back(int'(wrap));
      end
    end
    en = 1'b0;
  endtask

  task automatic apply_rows(input int first, input int last, input string tag);
    for (int i = first; i <= last; i++) begin
      en = tbl[i].en; clr = tbl[i].clr; ld = tbl[i].ld;
      ftw = tbl[i].ftw; mode = tbl[i].mode;
      @(posedge clk); #1;
      check($sformatf("%s[%0d].valid", tag, i), int'(sample_valid), int'(tbl[i].exp_v));
      check($sformatf("%s[%0d].sample", tag, i), int'(sample), tbl[i].exp_s);
      check($sformatf("%s[%0d].wrap", tag, i), int'(wrap), int'(tbl[i].exp_w));
    end
    en = 1'b0; clr = 1'b0; ld = 1'b0;
  endtask

  initial begin
    int bad, mx, mn, e;

    // Sine start-up: hold after release, load, then 3-cycle latency.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 512, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b0, 512, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 16'h0100, 2'd0, 1'b0, 512, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'h0100, 2'd0, 1'b0, 512, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'h0100, 2'd0, 1'b0, 512, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'h0100, 2'd0, 1'b1, 515, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 16'h0100, 2'd0, 1'b1, 528, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h0100, 2'd0, 1'b1, 540, 1'b0};
    // Saw (value = phase >> 6): ftw reload, 5 bubbles, phase clear.
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'h0100, 2'd2, 1'b0, 512, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 16'h0100, 2'd2, 1'b0, 512, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 16'h0100, 2'd2, 1'b0, 512, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 16'h0100, 2'd2, 1'b1, 0,   1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 16'h0100, 2'd2, 1'b1, 4,   1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 16'h0100, 2'd2, 1'b1, 8,   1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 16'h0200, 2'd2, 1'b1, 12,  1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 16'h0200, 2'd2, 1'b1, 16,  1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 16'h0200, 2'd2, 1'b1, 20,  1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 16'h0200, 2'd2, 1'b1, 24,  1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 16'h0200, 2'd2, 1'b1, 32,  1'b0};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 16'h0200, 2'd2, 1'b0, 32,  1'b0};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 16'h0200, 2'd2, 1'b0, 32,  1'b0};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 16'h0200, 2'd2, 1'b0, 32,  1'b0};
    tbl[22] = '{1'b1, 1'b0, 1'b0, 16'h0200, 2'd2, 1'b0, 32,  1'b0};
    tbl[23] = '{1'b1, 1'b0, 1'b0, 16'h0200, 2'd2, 1'b0, 32,  1'b0};
    tbl[24] = '{1'b1, 1'b0, 1'b0, 16'h0200, 2'd2, 1'b1, 40,  1'b0};
    tbl[25] = '{1'b1, 1'b1, 1'b0, 16'h0200, 2'd2, 1'b1, 48,  1'b0};
    tbl[26] = '{1'b1, 1'b0, 1'b0, 16'h0200, 2'd2, 1'b1, 56,  1'b0};
    tbl[27] = '{1'b1, 1'b0, 1'b0, 16'h0200, 2'd2, 1'b1, 64,  1'b0};
    tbl[28] = '{1'b0, 1'b0, 1'b0, 16'h0200, 2'd2, 1'b1, 0,   1'b0};
    tbl[29] = '{1'b0, 1'b0, 1'b0, 16'h0200, 2'd2, 1'b1, 8,   1'b0};

    // Asynchronous reset seen before the first clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst.sample", int'(sample), 512);
    check("rst.valid", int'(sample_valid), 0);
    check("rst.wrap", int'(wrap), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    apply_rows(0, 7, "sine_start");

    do_reset();
    apply_rows(8, 29, "ctrl");

    // Sine sweep, ftw = 0x0100: 256-sample period.
    do_reset();
    load(16'h0100, 2'd0);
    run_en(520);
    check("sine.count", s_q.size(), 520);
    check("sine.s0", s_q[0], 515);
    check("sine.s1", s_q[1], 528);
    check("sine.s64", s_q[64], 1023);
    check("sine.s128", s_q[128], 508);
    check("sine.s192", s_q[192], 0);
    mx = 0; mn = 1023;
    for (int k = 0; k < 256; k++) begin
      if (s_q[k] > mx) mx = s_q[k];
      if (s_q[k] < mn) mn = s_q[k];
    end
    check("sine.max", mx, 1023);
    check("sine.min", mn, 0);
    bad = 0;
    for (int k = 0; k < 384; k++) if (s_q[k] + s_q[k+128] != 1023) bad++;
    check("sine.half_mirror_bad", bad, 0);
    bad = 0;
    for (int k = 0; k < 264; k++) if (s_q[k] != s_q[k+256]) bad++;
    check("sine.period_bad", bad, 0);
    bad = 0;
    for (int k = 0; k < 520; k++) if (w_q[k] != int'(k % 256 == 255)) bad++;
    check("sine.wrap_bad", bad, 0);

    // Square, ftw = 0x1000: 8 high, 8 low.
    do_reset();
    load(16'h1000, 2'd3);
    run_en(48);
    check("sqr.count", s_q.size(), 48);
    bad = 0;
    for (int k = 0; k < 48; k++) if (s_q[k] != (((k % 16) < 8) ? 1023 : 0)) bad++;
    check("sqr.value_bad", bad, 0);
    bad = 0;
    for (int k = 0; k < 48; k++) if (w_q[k] != int'(k % 16 == 15)) bad++;
    check("sqr.wrap_bad", bad, 0);

    // Sawtooth, ftw = 0x0040: one code per sample.
    do_reset();
    load(16'h0040, 2'd2);
    run_en(1100);
    check("saw.count", s_q.size(), 1100);
    check("saw.s1023", s_q[1023], 1023);
    check("saw.s1024", s_q[1024], 0);
    bad = 0;
    for (int k = 0; k < 1100; k++) if (s_q[k] != k % 1024) bad++;
    check("saw.value_bad", bad, 0);
    bad = 0;
    for (int k = 0; k < 1100; k++) if (w_q[k] != int'(k % 1024 == 1023)) bad++;
    check("saw.wrap_bad", bad, 0);

    // Triangle, ftw = 0x0040: up in steps of 2, then down.
    do_reset();
    load(16'h0040, 2'd1);
    run_en(1100);
    check("tri.count", s_q.size(), 1100);
    check("tri.s511", s_q[511], 1022);
    check("tri.s512", s_q[512], 1023);
    check("tri.s1023", s_q[1023], 1);
    bad = 0;
    for (int k = 0; k < 1100; k++) begin
      e = ((k % 1024) < 512) ? 2 * (k % 1024) : 2047 - 2 * (k % 1024);
      if (s_q[k] != e) bad++;
    end
    check("tri.value_bad", bad, 0);

    // ftw left at zero after reset: constant mid-phase sine, valid, no wrap.
    do_reset();
    mode = 2'd0;
    run_en(10);
    check("ftw0.count", s_q.size(), 10);
    bad = 0;
    for (int k = 0; k < 10; k++) if (s_q[k] != 515 || w_q[k] != 0) bad++;
    check("ftw0.bad", bad, 0);

    // Asynchronous reset mid-run.
    do_reset();
    load(16'h0100, 2'd0);
    en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("midrst.pre_valid", int'(sample_valid), 1);
    #3 rst = 1'b1;
    #1;
    check("midrst.sample", int'(sample), 512);
    check("midrst.valid", int'(sample_valid), 0);
    check("midrst.wrap", int'(wrap), 0);
    en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst.hold", int'(sample), 512);
    load(16'h0100, 2'd0);
    run_en(5);
    check("midrst.count", s_q.size(), 5);
    check("midrst.s0", s_q[0], 515);
    check("midrst.s1", s_q[1], 528);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
